// File: rtl/fetch_unit.sv
// Instruction fetch + IF/ID register: 1-cycle ack-to-IF/ID latency, id_stall parks a returned word in a hold slot (request paused).
// Optional FETCH_UNIT_PERF_CNT_EN adds fetch_cnt / drop_cnt counters.
module fetch_unit #(
    parameter int              PC_W     = 12,
    parameter int              INSTR_W  = 19,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    pc_in,
    output logic [PC_W-1:0]    pc_next,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               id_stall,
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc1
`ifdef FETCH_UNIT_PERF_CNT_EN
   ,output logic [31:0]        fetch_cnt,
    output logic [15:0]        drop_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DROP} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_ifid_valid;
    logic [INSTR_W-1:0]   r_ifid_instr;
    logic [PC_W-1:0]      r_ifid_pc1;
    logic [INSTR_W-1:0]   r_hold_instr;
    logic [PC_W-1:0]      r_hold_pc1;
    logic [PC_W-1:0]      r_drop_addr;

    logic                 w_req_state;
    logic                 w_ack;
    logic                 w_slot_free;
    logic [PC_W-1:0]      w_pc_inc;
    logic                 w_ifid_load;
    logic                 w_ifid_from_hold;
    logic                 w_hold_load;
    logic                 w_drop_load;
    logic                 w_discard;

    assign w_req_state = (r_state == S_FETCH) || (r_state == S_DROP);
    assign w_ack       = imem_ack && w_req_state;
    assign w_slot_free = !r_ifid_valid || !id_stall;
    assign w_pc_inc    = pc_in + PC_W'(1);

    // Reset is synchronous, so the request must be gated directly by rst to drop in the same cycle.
    assign imem_req   = rst && w_req_state;
    assign imem_addr  = (r_state == S_DROP) ? r_drop_addr : pc_in;

    assign ifid_valid = r_ifid_valid;
    assign ifid_instr = r_ifid_instr;
    assign ifid_pc1   = r_ifid_pc1;

    always_comb begin
        w_state_nxt      = r_state;
        pc_next          = pc_in;
        w_ifid_load      = 1'b0;
        w_ifid_from_hold = 1'b0;
        w_hold_load      = 1'b0;
        w_drop_load      = 1'b0;
        w_discard        = 1'b0;
        if (redirect) begin
            pc_next = redirect_pc;
            unique case (r_state)
                S_IDLE:  w_state_nxt = S_FETCH;
                S_HOLD: begin
                    w_state_nxt = S_FETCH;
                    w_discard   = 1'b1;
                end
                S_FETCH: begin
                    if (w_ack) begin
                        w_discard = 1'b1;
                    end else begin
                        w_drop_load = 1'b1;
                        w_state_nxt = S_DROP;
                    end
                end
                S_DROP:  w_discard = w_ack;
                default: w_state_nxt = S_IDLE;
            endcase
        end else begin
            unique case (r_state)
                S_IDLE:  w_state_nxt = S_FETCH;
                S_FETCH: begin
                    if (w_ack) begin
                        pc_next = w_pc_inc;
                        if (w_slot_free) begin
                            w_ifid_load = 1'b1;
                        end else begin
                            w_hold_load = 1'b1;
                            w_state_nxt = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_slot_free) begin
                        w_ifid_load      = 1'b1;
                        w_ifid_from_hold = 1'b1;
                        w_state_nxt      = S_FETCH;
                    end
                end
                S_DROP: begin
                    if (w_ack) begin
                        w_discard   = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
        if (!rst) begin
            pc_next = RESET_PC;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= '0;
            r_ifid_pc1   <= '0;
            r_hold_instr <= '0;
            r_hold_pc1   <= '0;
            r_drop_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hold_load) begin
                r_hold_instr <= imem_data;
                r_hold_pc1   <= w_pc_inc;
            end
            if (w_drop_load) begin
                r_drop_addr <= pc_in;
            end
            if (redirect) begin
                r_ifid_valid <= 1'b0;
            end else if (w_ifid_load) begin
                r_ifid_valid <= 1'b1;
                r_ifid_instr <= w_ifid_from_hold ? r_hold_instr : imem_data;
                r_ifid_pc1   <= w_ifid_from_hold ? r_hold_pc1   : w_pc_inc;
            end else if (!id_stall) begin
                r_ifid_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_UNIT_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_ifid_load && !redirect) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_discard) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign drop_cnt  = r_drop_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic, all checked against a transaction-level model.
module tb_fetch_unit;
    localparam int              PC_W     = 12;
    localparam int              INSTR_W  = 19;
    localparam logic [PC_W-1:0] RESET_PC = 12'h000;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [PC_W-1:0]    pc_in = 12'h000;
    logic [PC_W-1:0]    pc_next;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;
    logic               redirect = 1'b0;
    logic [PC_W-1:0]    redirect_pc = 12'h000;
    logic               id_stall = 1'b0;
    logic               ifid_valid;
    logic [INSTR_W-1:0] ifid_instr;
    logic [PC_W-1:0]    ifid_pc1;
    logic               ack_en = 1'b0;
`ifdef FETCH_UNIT_PERF_CNT_EN
    logic [31:0]        fetch_cnt;
    logic [15:0]        drop_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .pc_next    (pc_next),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .id_stall   (id_stall),
        .ifid_valid (ifid_valid),
        .ifid_instr (ifid_instr),
        .ifid_pc1   (ifid_pc1)
`ifdef FETCH_UNIT_PERF_CNT_EN
       ,.fetch_cnt  (fetch_cnt),
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // External PC register and instruction memory (content is a fixed function of address).
    always @(posedge clk) pc_in <= pc_next;

    function automatic logic [INSTR_W-1:0] mem_word(input logic [PC_W-1:0] a);
        return {a ^ 12'h5A3, a[6:0] ^ 7'h2B};
    endfunction

    assign imem_ack  = imem_req & ack_en;
    assign imem_data = mem_word(imem_addr);

    // Model: a pending request (possibly stale), an optional parked word, and the IF/ID slot.
    bit                 m_startup = 1'b1;
    bit                 m_held_v  = 1'b0;
    logic [INSTR_W-1:0] m_held_i  = '0;
    logic [PC_W-1:0]    m_held_p  = '0;
    bit                 m_stale   = 1'b0;
    logic [PC_W-1:0]    m_stale_a = '0;
    bit                 m_v       = 1'b0;
    logic [INSTR_W-1:0] m_i       = '0;
    logic [PC_W-1:0]    m_p       = '0;
    int unsigned        m_fetch   = 0;
    int unsigned        m_drop    = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit rd, input logic [PC_W-1:0] rp,
                        input bit st, input bit ak);
        logic            e_req;
        logic            e_ack;
        logic [PC_W-1:0] e_addr;
        logic [PC_W-1:0] e_pcn;
        logic [PC_W-1:0] pc_cur;
        bit              free;
        bit              loaded;
        @(negedge clk);
        rst         = r;
        redirect    = rd;
        redirect_pc = rp;
        id_stall    = st;
        ack_en      = ak;
        #1;
        pc_cur = pc_in;
        e_req  = r && !m_startup && !m_held_v;
        e_ack  = e_req && ak;
        e_addr = m_stale ? m_stale_a : pc_cur;
        if (!r)                      e_pcn = RESET_PC;
        else if (rd)                 e_pcn = rp;
        else if (e_ack && !m_stale)  e_pcn = pc_cur + 12'd1;
        else                         e_pcn = pc_cur;
        check_eq("imem_req", 32'(imem_req), 32'(e_req));
        if (e_req) check_eq("imem_addr", 32'(imem_addr), 32'(e_addr));
        check_eq("pc_next", 32'(pc_next), 32'(e_pcn));
        @(posedge clk);
        if (!r) begin
            m_startup = 1'b1; m_held_v = 1'b0; m_stale = 1'b0;
            m_v = 1'b0; m_i = '0; m_p = '0; m_fetch = 0; m_drop = 0;
        end else begin
            free   = !m_v || !st;
            loaded = 1'b0;
            if (rd) begin
                if (m_held_v) m_drop++;
                m_held_v = 1'b0;
                if (e_ack) m_drop++;
                else if (e_req && !m_stale) begin
                    m_stale   = 1'b1;
                    m_stale_a = pc_cur;
                end
                m_v = 1'b0;
            end else begin
                if (m_held_v) begin
                    if (free) begin
                        m_v = 1'b1; m_i = m_held_i; m_p = m_held_p;
                        m_held_v = 1'b0; loaded = 1'b1; m_fetch++;
                    end
                end else if (e_ack) begin
                    if (m_stale) begin
                        m_stale = 1'b0;
                        m_drop++;
                    end else if (free) begin
                        m_v = 1'b1; m_i = mem_word(pc_cur); m_p = pc_cur + 12'd1;
                        loaded = 1'b1; m_fetch++;
                    end else begin
                        m_held_v = 1'b1; m_held_i = mem_word(pc_cur); m_held_p = pc_cur + 12'd1;
                    end
                end
                if (!loaded && !st) m_v = 1'b0;
            end
            m_startup = 1'b0;
        end
        #1;
        check_eq("ifid_valid", 32'(ifid_valid), 32'(m_v));
        if (m_v) begin
            check_eq("ifid_instr", 32'(ifid_instr), 32'(m_i));
            check_eq("ifid_pc1", 32'(ifid_pc1), 32'(m_p));
        end
`ifdef FETCH_UNIT_PERF_CNT_EN
        check_eq("fetch_cnt", fetch_cnt, m_fetch);
        check_eq("drop_cnt", 32'(drop_cnt), 32'(m_drop[15:0]));
`endif
    endtask

    initial begin
        // Reset state
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
        check_eq("rst_ifid_instr", 32'(ifid_instr), 32'h0);
        check_eq("rst_ifid_pc1", 32'(ifid_pc1), 32'h0);

        // Zero-wait memory from PC 0: one instruction per cycle after the IDLE cycle
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b0, 12'h000, 1'b0, 1'b1);
            check_eq("zw_pc1", 32'(ifid_pc1), 32'(i));
            check_eq("zw_valid", 32'(ifid_valid), 32'h1);
        end

        // PC wrap at 0xFFF
        step(1'b1, 1'b1, 12'hFFF, 1'b0, 1'b1);
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b1);
        check_eq("wrap_pc1", 32'(ifid_pc1), 32'h000);

        // Decode stall during ack of 0x010 parks it; release moves it into IF/ID
        step(1'b1, 1'b1, 12'h00F, 1'b0, 1'b1);
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b1);
        step(1'b1, 1'b0, 12'h000, 1'b1, 1'b1);
        step(1'b1, 1'b0, 12'h000, 1'b1, 1'b1);
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
        check_eq("hold_pc1", 32'(ifid_pc1), 32'h011);
        check_eq("hold_instr", 32'(ifid_instr), 32'(mem_word(12'h010)));

        // 3-wait memory, redirect to 0x200 in the first wait cycle
        step(1'b1, 1'b1, 12'h200, 1'b0, 1'b0);
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b1);
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
        check_eq("drop_target_addr", 32'(imem_addr), 32'h200);

        // Redirect coinciding with ack
        step(1'b1, 1'b1, 12'h040, 1'b0, 1'b1);
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
        check_eq("redir_ack_addr", 32'(imem_addr), 32'h040);

        // Reset in the middle of a wait
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b1);
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [PC_W-1:0] rp;
            rp = ($urandom_range(0, 7) == 0) ? 12'hFFF : PC_W'($urandom_range(0, 4095));
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 11) == 0),
                 rp,
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 1) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that closes the loop around the 12-bit PC register. It consumes the register's current value, drives its next value, and runs the request/acknowledge handshake to instruction memory. It also owns the IF/ID pipeline register, handling decode stalls, branch/jump redirects, and in-flight responses made stale by a redirect.

## Interface
Parameters:
- PC_W, 12, PC and instruction-address width
- INSTR_W, 19, instruction width
- RESET_PC, 0, value driven on pc_next while in reset

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low
- pc_in  in  PC_W  current PC from the PC register output
- pc_next  out  PC_W  next PC, to the PC register input (loaded every cycle)
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address, stable while imem_req is high and no ack has arrived
- imem_ack  in  1  response strobe, sampled only while imem_req is high
- imem_data  in  INSTR_W  instruction, valid with imem_ack
- redirect  in  1  branch/jump taken, flush
- redirect_pc  in  PC_W  redirect target
- id_stall  in  1  decode cannot consume IF/ID this cycle
- ifid_valid  out  1  IF/ID holds a live instruction
- ifid_instr  out  INSTR_W  IF/ID instruction
- ifid_pc1  out  PC_W  fetch address + 1, modulo 2^PC_W

## Operation
- The IF/ID slot is free when `!ifid_valid || !id_stall`.
- FSM states: IDLE, FETCH, HOLD, DROP. Reset enters IDLE.
- IDLE
  - Lasts exactly 1 cycle, then goes to FETCH.
  - imem_req=0, pc_next=pc_in.
- FETCH
  - imem_req=1, imem_addr=pc_in.
  - Until ack: pc_next=pc_in.
  - Ack with slot free: load IF/ID with imem_data and pc_in+1, set ifid_valid, set pc_next=pc_in+1, stay in FETCH.
  - Ack with slot blocked: store the instruction and pc_in+1 in the hold register, set pc_next=pc_in+1, go to HOLD.
- HOLD
  - imem_req=0, pc_next=pc_in.
  - When the slot frees: move the hold register into IF/ID, go to FETCH.
- DROP
  - imem_req=1, imem_addr=drop_addr (the address outstanding when the redirect hit).
  - pc_next=pc_in.
  - On ack: discard imem_data, go to FETCH.
- Redirect has highest priority in every state:
  - pc_next=redirect_pc.
  - ifid_valid<=0; the hold register is discarded.
  - In FETCH without ack the same cycle: drop_addr<=pc_in, go to DROP.
  - In FETCH with ack the same cycle: discard the data, go to FETCH.
  - In DROP: stay in DROP, drop_addr unchanged.
  - In IDLE or HOLD: go to FETCH.
- IF/ID is consumed when ifid_valid && !id_stall. If nothing new is loaded that cycle, ifid_valid<=0.
- PC arithmetic is modulo 2^PC_W: address 0xFFF + 1 = 0x000, with no flag.
- Reset mid-operation aborts any request with no handshake completion. Memory must tolerate imem_req dropping without an ack.
- Reset values: FSM=IDLE, ifid_valid=0, ifid_instr=0, ifid_pc1=0, imem_req=0, hold/drop registers=0, pc_next=RESET_PC (combinational while rst=0).

## Timing
- pc_next, imem_req and imem_addr are combinational from state and inputs. All other outputs are registered.
- Ack in cycle n:
  - IF/ID is valid in cycle n+1.
  - The next request at the incremented PC is issued in cycle n+1.
- With a zero-wait memory (ack in the same cycle as req), throughput is 1 instruction/cycle.
- Redirect in cycle n:
  - pc_next=redirect_pc in cycle n.
  - ifid_valid=0 in cycle n+1.
  - The target request goes out in cycle n+1, unless the FSM is in DROP, in which case it goes out the cycle after the stale ack.
- imem_req falls only after an ack, a HOLD entry, or reset.

## Configuration
- Macro: FETCH_UNIT_PERF_CNT_EN.
- Defined: adds two output ports.
  - fetch_cnt (32 bits): increments on each IF/ID load.
  - drop_cnt (16 bits): increments on each discarded response and each discarded hold entry.
  - Both wrap and reset to 0.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- Reset + zero-wait memory, pc from 0x000, no stall -> cycles 1..4 after IDLE give IF/ID pc1 = 0x001, 0x002, 0x003, 0x004, ifid_valid held at 1.
- pc_in=0xFFF, ack -> pc_next=0x000, ifid_pc1=0x000.
- id_stall=1 with IF/ID valid, ack for 0x010 -> HOLD, imem_req=0, pc_next=0x011. Release stall -> IF/ID = hold entry next cycle, then request at 0x011.
- 3-wait memory, redirect to 0x200 in wait cycle 1 -> DROP, imem_addr stays at the old address until ack, data discarded, next request at 0x200, ifid_valid=0 throughout. With the macro defined, drop_cnt=1.
- Redirect to 0x040 in the same cycle as ack -> data discarded, request at 0x040 next cycle.
- rst=0 asserted in FETCH mid-wait -> next cycle imem_req=0, ifid_valid=0, pc_next=RESET_PC, then IDLE for 1 cycle after release.
